// File: rtl/inst_disasm_stream.sv
// inst_disasm_stream: time-shared RV32I disassembler feeding a character RAM.
// A refresh snapshots one instruction word per channel. Each channel is then
// decoded into a fixed-width ASCII line, and the line is written out one
// character per accepted cycle.
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   refresh          frame request (level, sampled every clock)
//   code_bus         N_CH packed 32-bit instruction words, ch k at [32k+31:32k]
//   busy             frame in progress
//   ch_wr_en/addr/data  char-RAM write; a write is accepted when en && ch_wr_ready
//   ch_wr_ready      sink ready
//   frame_done       one-cycle pulse when a frame completes
module inst_disasm_stream #(
    parameter int unsigned N_CH    = 5,
    parameter int unsigned STR_LEN = 19,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   refresh,
    input  logic [32*N_CH-1:0]     code_bus,
    output logic                   busy,
    output logic                   ch_wr_en,
    output logic [ADDR_W-1:0]      ch_wr_addr,
    output logic [7:0]             ch_wr_data,
    input  logic                   ch_wr_ready,
    output logic                   frame_done
);

    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned COL_W   = $clog2(STR_LEN);
    localparam int unsigned TXT_LEN = 19;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EMIT, S_DONE} state_e;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U} fmt_e;

    state_e                    state_q, state_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic                      pending_q, pending_d;
    logic [31:0]               snap_q [N_CH];
    logic [31:0]               snap_d [N_CH];
    logic [STR_LEN-1:0][7:0]   line_q, line_d;
    logic                      busy_q, busy_d;
    logic                      wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [7:0]                data_q, data_d;
    logic                      done_q, done_d;

    // Decoder signals
    logic [31:0]               ins;
    logic [6:0]                op;
    logic [2:0]                f3;
    logic [6:0]                f7;
    logic [4:0]                rd, rs1, rs2;
    logic [47:0]               mn;
    fmt_e                      fmt;
    logic                      legal;
    logic                      is_shift;
    logic [11:0]               imm_i, imm_s;
    logic [12:0]               imm_b;
    logic [20:0]               imm_j;
    logic [TXT_LEN*8-1:0]      txt;
    logic [STR_LEN*8-1:0]      full;
    logic [STR_LEN-1:0][7:0]   dec_line;

    function automatic logic [7:0] hex_c(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h37 + 8'(v));
    endfunction

    function automatic logic [23:0] reg_s(input logic [4:0] r);
        return {"x", hex_c({3'b000, r[4]}), hex_c(r[3:0])};
    endfunction

    function automatic logic [23:0] hex3(input logic [11:0] v);
        return {hex_c(v[11:8]), hex_c(v[7:4]), hex_c(v[3:0])};
    endfunction

    function automatic logic [31:0] hex4(input logic [15:0] v);
        return {hex_c(v[15:12]), hex3(v[11:0])};
    endfunction

    function automatic logic [39:0] hex5(input logic [19:0] v);
        return {hex_c(v[19:16]), hex4(v[15:0])};
    endfunction

    function automatic logic [47:0] hex6(input logic [23:0] v);
        return {hex_c(v[23:20]), hex5(v[19:0])};
    endfunction

    // Combinational decode of the current channel's snapshot into a text line
    always_comb begin
        ins      = snap_q[ch_q];
        op       = ins[6:0];
        f3       = ins[14:12];
        f7       = ins[31:25];
        rd       = ins[11:7];
        rs1      = ins[19:15];
        rs2      = ins[24:20];
        mn       = "      ";
        fmt      = FMT_R;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (op)
            7'h33: begin
                fmt = FMT_R;
                case ({f7, f3})
                    {7'h00, 3'd0}: mn = "add   ";
                    {7'h20, 3'd0}: mn = "sub   ";
                    {7'h00, 3'd1}: mn = "sll   ";
                    {7'h00, 3'd2}: mn = "slt   ";
                    {7'h00, 3'd3}: mn = "sltu  ";
                    {7'h00, 3'd4}: mn = "xor   ";
                    {7'h00, 3'd5}: mn = "srl   ";
                    {7'h20, 3'd5}: mn = "sra   ";
                    {7'h00, 3'd6}: mn = "or    ";
                    {7'h00, 3'd7}: mn = "and   ";
                    default:       legal = 1'b0;
                endcase
            end
            7'h13: begin
                fmt = FMT_I;
                case (f3)
                    3'd0: mn = "addi  ";
                    3'd2: mn = "slti  ";
                    3'd3: mn = "sltiu ";
                    3'd4: mn = "xori  ";
                    3'd6: mn = "ori   ";
                    3'd7: mn = "andi  ";
                    3'd1: begin
                        is_shift = 1'b1;
                        mn       = "slli  ";
                        legal    = (f7 == 7'h00);
                    end
                    default: begin
                        is_shift = 1'b1;
                        if (f7 == 7'h00)      mn = "srli  ";
                        else if (f7 == 7'h20) mn = "srai  ";
                        else                  legal = 1'b0;
                    end
                endcase
            end
            7'h03: begin
                fmt = FMT_I;
                case (f3)
                    3'd0:    mn = "lb    ";
                    3'd1:    mn = "lh    ";
                    3'd2:    mn = "lw    ";
                    3'd4:    mn = "lbu   ";
                    3'd5:    mn = "lhu   ";
                    default: legal = 1'b0;
                endcase
            end
            7'h67: begin
                fmt   = FMT_I;
                mn    = "jalr  ";
                legal = (f3 == 3'd0);
            end
            7'h23: begin
                fmt = FMT_S;
                case (f3)
                    3'd0:    mn = "sb    ";
                    3'd1:    mn = "sh    ";
                    3'd2:    mn = "sw    ";
                    default: legal = 1'b0;
                endcase
            end
            7'h63: begin
                fmt = FMT_B;
                case (f3)
                    3'd0:    mn = "beq   ";
                    3'd1:    mn = "bne   ";
                    3'd4:    mn = "blt   ";
                    3'd5:    mn = "bge   ";
                    3'd6:    mn = "bltu  ";
                    3'd7:    mn = "bgeu  ";
                    default: legal = 1'b0;
                endcase
            end
            7'h6F: begin
                fmt = FMT_J;
                mn  = "jal   ";
            end
            7'h37: begin
                fmt = FMT_U;
                mn  = "lui   ";
            end
            7'h17: begin
                fmt = FMT_U;
                mn  = "auipc ";
            end
            default: legal = 1'b0;
        endcase

        imm_i = is_shift ? {7'b0, ins[24:20]} : ins[31:20];
        imm_s = {ins[31:25], ins[11:7]};
        imm_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

        case (fmt)
            FMT_R:   txt = {mn, reg_s(rd), ",", reg_s(rs1), ",", reg_s(rs2), "  "};
            FMT_I:   txt = {mn, reg_s(rd), ",", reg_s(rs1), ",", hex3(imm_i), "H", " "};
            FMT_S:   txt = {mn, reg_s(rs1), ",", reg_s(rs2), ",", hex3(imm_s), "H", " "};
            FMT_B:   txt = {mn, reg_s(rs1), ",", reg_s(rs2), ",", hex4({3'b0, imm_b}), " "};
            FMT_J:   txt = {mn, reg_s(rd), ",", hex6({3'b0, imm_j}), "H", "  "};
            default: txt = {mn, reg_s(rd), ",", hex5(ins[31:12]), "H", "   "};
        endcase
        if (!legal)              txt = "illegal instruction";
        // Pipeline bubbles get their own labels ahead of the plain addi decode
        if (ins == 32'h0000_0000) txt = "nop DStall:lw 00   ";
        if (ins == 32'h0000_0013) txt = "nop JStall:addi0   ";

        full = {STR_LEN{8'h20}};
        full[STR_LEN*8-1 -: TXT_LEN*8] = txt;
        for (int unsigned i = 0; i < STR_LEN; i++) begin
            dec_line[i] = full[(STR_LEN-1-i)*8 +: 8];
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        col_d     = col_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        line_d    = line_q;
        addr_d    = addr_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (refresh) begin
                    for (int unsigned k = 0; k < N_CH; k++) snap_d[k] = code_bus[32*k +: 32];
                    ch_d    = '0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (refresh) pending_d = 1'b1;
                line_d  = dec_line;
                col_d   = '0;
                addr_d  = ADDR_W'(ch_q * STR_LEN);
                data_d  = dec_line[0];
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (refresh) pending_d = 1'b1;
                if (ch_wr_ready) begin
                    if (col_q == COL_W'(STR_LEN - 1)) begin
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = S_DECODE;
                        end
                    end else begin
                        col_d  = col_q + COL_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        data_d = line_q[col_q + COL_W'(1)];
                    end
                end
            end
            S_DONE: begin
                // A request arriving in this very cycle merges into the rerun
                if (pending_q || refresh) begin
                    pending_d = 1'b0;
                    for (int unsigned k = 0; k < N_CH; k++) snap_d[k] = code_bus[32*k +: 32];
                    ch_d      = '0;
                    state_d   = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        wr_en_d = (state_d == S_EMIT);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            col_q     <= '0;
            pending_q <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) snap_q[k] <= '0;
            line_q    <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            col_q     <= col_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign ch_wr_en   = wr_en_q;
    assign ch_wr_addr = addr_q;
    assign ch_wr_data = data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_inst_disasm_stream.sv
// Scoreboard bench for inst_disasm_stream: expected char writes are queued
// when a frame is requested; a negedge monitor pops and compares each write.
module tb_inst_disasm_stream;

    localparam int N_CH    = 5;
    localparam int STR_LEN = 19;
    localparam int ADDR_W  = 7;
    localparam int NV      = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 refresh;
    logic [32*N_CH-1:0]   code_bus;
    logic                 busy;
    logic                 ch_wr_en;
    logic [ADDR_W-1:0]    ch_wr_addr;
    logic [7:0]           ch_wr_data;
    logic                 ch_wr_ready;
    logic                 frame_done;

    inst_disasm_stream #(.N_CH(N_CH), .STR_LEN(STR_LEN), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .refresh    (refresh),
        .code_bus   (code_bus),
        .busy       (busy),
        .ch_wr_en   (ch_wr_en),
        .ch_wr_addr (ch_wr_addr),
        .ch_wr_data (ch_wr_data),
        .ch_wr_ready(ch_wr_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int busy_cnt, fd_cnt, wr_cnt, fd_rel, first_rel, first_addr;
    logic [14:0] sb_q[$];
    logic [14:0] sb_e;
    int cur [N_CH];
    logic [31:0] vec_w [NV];
    string       vec_s [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: statistics plus scoreboard comparison of every accepted write
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (busy) busy_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_rel = cyc - e0 + 1;
            end
            if (ch_wr_en && first_rel < 0) begin
                first_rel  = cyc - e0 + 1;
                first_addr = 32'(ch_wr_addr);
            end
            if (ch_wr_en && ch_wr_ready) begin
                wr_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_write", 32'(ch_wr_addr), 32'h7F);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("wr_addr", 32'(ch_wr_addr), 32'(sb_e[14:8]));
                    chk("wr_data", 32'(ch_wr_data), 32'(sb_e[7:0]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_stats();
        busy_cnt   = 0;
        fd_cnt     = 0;
        wr_cnt     = 0;
        fd_rel     = -1;
        first_rel  = -1;
        first_addr = -1;
    endtask

    task automatic set_bus(input int a, input int b, input int c, input int d, input int e);
        cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d; cur[4] = e;
        for (int k = 0; k < N_CH; k++) code_bus[32*k +: 32] = vec_w[cur[k]];
    endtask

    task automatic push_frame();
        string s;
        for (int ch = 0; ch < N_CH; ch++) begin
            s = vec_s[cur[ch]];
            for (int col = 0; col < STR_LEN; col++) begin
                sb_q.push_back({7'(ch*STR_LEN + col), 8'(s[col])});
            end
        end
    endtask

    task automatic fire();
        @(posedge clk); #1;
        refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic stall_at_24();
        int n = 0;
        while (!(ch_wr_en && ch_wr_addr == 7'd24) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_addr_found", 32'(ch_wr_addr), 32'd24);
        ch_wr_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_hold_en", 32'(ch_wr_en), 32'd1);
            chk("stall_hold_addr", 32'(ch_wr_addr), 32'd24);
            chk("stall_hold_data", 32'(ch_wr_data), 32'h53);
        end
        ch_wr_ready = 1'b1;
    endtask

    initial begin
        vec_w[0]  = 32'h002081B3; vec_s[0]  = "add   x03,x01,x02  ";
        vec_w[1]  = 32'h00000000; vec_s[1]  = "nop DStall:lw 00   ";
        vec_w[2]  = 32'h00000013; vec_s[2]  = "nop JStall:addi0   ";
        vec_w[3]  = 32'hFE62DCE3; vec_s[3]  = "bge   x05,x06,1FF8 ";
        vec_w[4]  = 32'h123452B7; vec_s[4]  = "lui   x05,12345H   ";
        vec_w[5]  = 32'hFFFFFFFF; vec_s[5]  = "illegal instruction";
        vec_w[6]  = 32'h4020D1B3; vec_s[6]  = "sra   x03,x01,x02  ";
        vec_w[7]  = 32'hFFF10093; vec_s[7]  = "addi  x01,x02,FFFH ";
        vec_w[8]  = 32'h00552423; vec_s[8]  = "sw    x0A,x05,008H ";
        vec_w[9]  = 32'h001000EF; vec_s[9]  = "jal   x01,000800H  ";
        vec_w[10] = 32'h40345393; vec_s[10] = "srai  x07,x08,003H ";
        vec_w[11] = 32'hABCDE117; vec_s[11] = "auipc x02,ABCDEH   ";

        rst = 1'b1; refresh = 1'b0; ch_wr_ready = 1'b1; code_bus = '0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(ch_wr_en), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_addr", 32'(ch_wr_addr), 32'd0);
        chk("rst_data", 32'(ch_wr_data), 32'd0);
        rst = 1'b0;

        // T1: basic frame timing and R/I/S/J/shift formats
        clr_stats(); set_bus(7, 8, 0, 9, 10); push_frame(); fire();
        wait_idle(300);
        chk("t1_first_wr_cycle", 32'(first_rel), 32'd2);
        chk("t1_frame_done_cycle", 32'(fd_rel), 32'd101);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd101);
        chk("t1_writes", 32'(wr_cnt), 32'd95);
        chk("t1_done_pulses", 32'(fd_cnt), 32'd1);
        chk("t1_sb_left", 32'(sb_q.size()), 32'd0);

        // T2: nops, B and U formats
        clr_stats(); set_bus(1, 2, 11, 3, 4); push_frame(); fire();
        wait_idle(300);
        chk("t2_done_pulses", 32'(fd_cnt), 32'd1);
        chk("t2_sb_left", 32'(sb_q.size()), 32'd0);

        // T3: three-cycle backpressure at address 24
        clr_stats(); set_bus(1, 2, 11, 3, 4); push_frame(); fire();
        fork
            stall_at_24();
            wait_idle(400);
        join
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd104);
        chk("t3_writes", 32'(wr_cnt), 32'd95);
        chk("t3_sb_left", 32'(sb_q.size()), 32'd0);

        // T4: refresh while busy, then bus change: old frame then one new frame
        clr_stats(); set_bus(7, 8, 0, 9, 10); push_frame(); fire();
        repeat (28) @(posedge clk);
        #1 refresh = 1'b1;
        @(posedge clk); #1;
        refresh = 1'b0;
        set_bus(1, 2, 11, 3, 4); push_frame();
        wait_idle(500);
        chk("t4_done_pulses", 32'(fd_cnt), 32'd2);
        chk("t4_writes", 32'(wr_cnt), 32'd190);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd202);
        chk("t4_sb_left", 32'(sb_q.size()), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_third_frame", 32'(busy), 32'd0);

        // T5: illegal word and sra
        clr_stats(); set_bus(5, 6, 0, 1, 2); push_frame(); fire();
        wait_idle(300);
        chk("t5_done_pulses", 32'(fd_cnt), 32'd1);
        chk("t5_sb_left", 32'(sb_q.size()), 32'd0);

        // T6: reset in the middle of channel 3
        clr_stats(); set_bus(7, 8, 0, 9, 10); push_frame(); fire();
        begin
            int n = 0;
            while (!(ch_wr_en && ch_wr_addr == 7'd60) && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("t6_reached_ch3", 32'(ch_wr_addr), 32'd60);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_wr_en", 32'(ch_wr_en), 32'd0);
        chk("t6_rst_frame_done", 32'(frame_done), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_done_after_abort", 32'(fd_cnt), 32'd0);
        chk("t6_idle_after_abort", 32'(busy), 32'd0);
        clr_stats(); set_bus(10, 9, 8, 7, 6); push_frame(); fire();
        wait_idle(300);
        chk("t6_restart_addr", 32'(first_addr), 32'd0);
        chk("t6_done_pulses", 32'(fd_cnt), 32'd1);
        chk("t6_writes", 32'(wr_cnt), 32'd95);
        chk("t6_sb_left", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
